// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: state encoding and frame field positions shared by the SPI register bank.
package spi_reg_pkg;
    typedef enum logic [1:0] {ARM, IDLE, SHIFT, DONE} state_t;
    function automatic int frame_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction
    function automatic int rw_bit(input int aw, input int dw);
        return aw + dw;
    endfunction
    function automatic int addr_msb(input int aw, input int dw);
        return aw + dw - 1;
    endfunction
    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction
    function automatic int data_msb(input int dw);
        return dw - 1;
    endfunction
    function automatic int data_lsb();
        return 0;
    endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: synchroniser chain with one-cycle rise/fall detection on the synchronised level.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] chain;
    logic prev;
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], pin};
            prev  <= sync;
        end
    end
    assign sync = chain[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral with a readable/writable bank of configuration registers.
module spi_reg_bank import spi_reg_pkg::*; #(
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err
);
    localparam int FW = frame_w(ADDR_W, DATA_W);
    localparam int CW = $clog2(FW + 1);
    localparam int AC = $clog2(SYNC_STAGES + 1);
    localparam int RW = rw_bit(ADDR_W, DATA_W);
    localparam int AM = addr_msb(ADDR_W, DATA_W);
    localparam int AL = addr_lsb(DATA_W);
    localparam int DM = data_msb(DATA_W);
    localparam int DL = data_lsb();

    logic sclk_s, sclk_r, sclk_f, ncs_s, ncs_r, ncs_f, copi_s, copi_unused_r, copi_unused_f;
    logic unused_copi_edges;
    assign unused_copi_edges = copi_unused_r ^ copi_unused_f;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk(clk), .rst(rst), .pin(sclk), .sync(sclk_s), .rise(sclk_r), .fall(sclk_f));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ncs (
        .clk(clk), .rst(rst), .pin(ncs), .sync(ncs_s), .rise(ncs_r), .fall(ncs_f));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_copi (
        .clk(clk), .rst(rst), .pin(copi), .sync(copi_s), .rise(copi_unused_r), .fall(copi_unused_f));

    state_t state, nxt;
    logic [AC-1:0] arm_cnt;
    logic [CW-1:0] bit_cnt, cnt_nxt;
    logic [FW-1:0] rx_sh, rx_nxt;
    logic [DATA_W-1:0] tx_sh, rd_data;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic fend, full, hit, commit, bad, load;

    assign rx_nxt  = {rx_sh[FW-2:0], copi_s};
    assign cnt_nxt = bit_cnt + 1'b1;
    assign fend    = (state == SHIFT || state == DONE) && ncs_r;
    assign full    = bit_cnt == CW'(FW);
    assign commit  = fend && full && rx_sh[RW] && hit;
    assign bad     = fend && !full;
    assign load    = state == SHIFT && !ncs_r && sclk_r && cnt_nxt == CW'(1 + ADDR_W) && !rx_nxt[ADDR_W];

    always_comb begin
        rd_data = '0;
        hit     = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rx_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_data = regs[i];
            if (rx_sh[AM:AL] == ADDR_W'(i)) hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ARM;
        else     state <= nxt;
    end

    // The synchroniser reset values are not the pin, so ARM only releases once ncs has
    // read high for long enough that the chain reflects the real pin level.
    always_comb begin
        nxt = state;
        case (state)
            ARM:   nxt = (ncs_s && arm_cnt == AC'(SYNC_STAGES)) ? IDLE : ARM;
            IDLE:  nxt = ncs_f ? SHIFT : IDLE;
            SHIFT: nxt = ncs_r ? IDLE : (sclk_r && cnt_nxt == CW'(FW)) ? DONE : SHIFT;
            DONE:  nxt = ncs_r ? IDLE : DONE;
            default: nxt = ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            arm_cnt   <= '0;
            bit_cnt   <= '0;
            rx_sh     <= '0;
            tx_sh     <= '0;
            wr_addr   <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            arm_cnt   <= !ncs_s ? '0 : (arm_cnt == AC'(SYNC_STAGES)) ? arm_cnt : arm_cnt + 1'b1;
            wr_strobe <= commit;
            frame_err <= bad;
            if (commit) wr_addr <= rx_sh[AM:AL];
            for (int i = 0; i < NUM_REGS; i++)
                if (commit && rx_sh[AM:AL] == ADDR_W'(i)) regs[i] <= rx_sh[DM:DL];
            if (state == IDLE && ncs_f) begin
                bit_cnt <= '0;
                rx_sh   <= '0;
                tx_sh   <= '0;
            end else if (fend) begin
                tx_sh <= '0;
            end else if (state == SHIFT && sclk_r) begin
                rx_sh   <= rx_nxt;
                bit_cnt <= cnt_nxt;
                if (load) tx_sh <= rd_data;
            end else if (state == SHIFT && sclk_f && bit_cnt > CW'(1 + ADDR_W)) begin
                // The fall right after the load keeps the MSB on cipo for the next rise.
                tx_sh <= tx_sh << 1;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g++) begin : g_flat
            assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
        end
    endgenerate

    assign cipo    = tx_sh[DATA_W-1];
    assign cipo_oe = ~ncs_s;
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: randomized SPI frames checked against a register-array model through an event scoreboard.
module tb_spi_reg_bank;
    localparam int NR = 5, AW = 7, DW = 8, SS = 2, HALF = 5;

    logic clk = 1'b0, rst = 1'b1, sclk = 1'b0, ncs = 1'b1, copi = 1'b0;
    logic cipo, cipo_oe, wr_strobe, frame_err;
    logic [NR*DW-1:0] regs_flat;
    logic [AW-1:0] wr_addr;

    always #5 clk = ~clk;

    spi_reg_bank #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
        .cipo_oe(cipo_oe), .regs_flat(regs_flat), .wr_strobe(wr_strobe),
        .wr_addr(wr_addr), .frame_err(frame_err));

    typedef struct packed {
        logic          err;
        logic [AW-1:0] addr;
        logic [NR*DW-1:0] regs;
    } ev_t;

    ev_t exp_q[$];
    logic [DW-1:0] model [NR];
    logic [AW-1:0] last_addr;
    int checks = 0, errors = 0;

    function automatic logic [NR*DW-1:0] flat();
        logic [NR*DW-1:0] f;
        f = '0;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe or frame error must match the oldest outstanding expectation.
    ev_t e;
    always @(negedge clk) begin
        if (!rst && (wr_strobe || frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: strobe=%0b err=%0b addr=%0h, no event expected",
                         wr_strobe, frame_err, wr_addr);
            end else begin
                e = exp_q.pop_front();
                if ({wr_strobe, frame_err} !== {!e.err, e.err} || wr_addr !== e.addr || regs_flat !== e.regs) begin
                    errors++;
                    $display("FAIL event: got strobe=%0b err=%0b addr=%0h regs=%0h, expected strobe=%0b err=%0b addr=%0h regs=%0h",
                             wr_strobe, frame_err, wr_addr, regs_flat, !e.err, e.err, e.addr, e.regs);
                end
            end
        end
    end

    task automatic reset_model();
        for (int i = 0; i < NR; i++) model[i] = '0;
        last_addr = '0;
        exp_q.delete();
    endtask

    task automatic send(input logic [31:0] bits, input int n, input int rst_at, output logic [31:0] cap);
        cap = '0;
        ncs = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (k == rst_at) begin
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
                reset_model();
                check("rst_mid_frame_regs", regs_flat, '0);
            end
            copi = bits[n-1-k];
            repeat (HALF) @(negedge clk);
            cap[n-1-k] = cipo;
            if (k == 0 && rst_at < 0) check("cipo_oe", cipo_oe, 1);
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        ncs = 1'b1;
        copi = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic post_frame();
        check("queue_drained", 64'(exp_q.size()), 0);
        exp_q.delete();
        check("regs_after_frame", regs_flat, flat());
    endtask

    task automatic frame(input logic [31:0] bits, input int n);
        logic [31:0] cap;
        logic [15:0] w;
        int idx;
        w = (n >= 16) ? 16'(bits >> (n - 16)) : 16'h0;
        idx = int'(w[14:8]);
        if (n < 16) exp_q.push_back('{1'b1, last_addr, flat()});
        else if (w[15] && idx < NR) begin
            model[idx] = w[7:0];
            last_addr = w[14:8];
            exp_q.push_back('{1'b0, last_addr, flat()});
        end
        send(bits, n, -1, cap);
        if (n >= 16 && !w[15]) check("read_data", cap[n-9 -: 8], (idx < NR) ? model[idx] : 8'h00);
        post_frame();
    endtask

    initial begin
        logic [31:0] cap, b;
        logic [15:0] f;
        int n;
        reset_model();
        repeat (4) @(negedge clk);
        check("rst_regs", regs_flat, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_cipo", cipo, 0);
        check("rst_cipo_oe", cipo_oe, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        frame(32'h82A5, 16);
        frame(32'h843C, 16);
        frame(32'h0400, 16);
        frame(32'hABC, 12);
        frame(32'h8177, 16);
        frame(32'h810FF, 20);
        frame(32'hFF12, 16);
        frame(32'h7F00, 16);
        frame(32'h0, 0);
        send(32'h82FF, 16, 6, cap);
        post_frame();
        frame(32'h8311, 16);
        frame(32'h0300, 16);
        for (int t = 0; t < 40; t++) begin
            n = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(1, 22));
            f[15]   = 1'($urandom_range(0, 1));
            f[14:8] = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, NR - 1));
            f[7:0]  = 8'($urandom);
            b = (n >= 16) ? (({16'h0, f} << (n - 16)) | ($urandom & ((32'd1 << (n - 16)) - 1)))
                          : 32'(f >> (16 - n));
            frame(b, n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
